// File: rtl/id_pipe.sv
// Decode stage with a registered ID/EX boundary, operand forwarding and load-use stall.
// Define ID_MEM_FWD_EN to forward from MEM; otherwise a MEM-stage match stalls instead.
module id_pipe #(
  parameter int DATA_W   = 32,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_i,
  input  logic [31:0]         inst_i,
  input  logic                inst_valid_i,
  output logic                id_ready_o,
  output logic                reg1_read_o,
  output logic                reg2_read_o,
  output logic [RADDR_W-1:0]  reg1_addr_o,
  output logic [RADDR_W-1:0]  reg2_addr_o,
  input  logic [DATA_W-1:0]   reg1_data_i,
  input  logic [DATA_W-1:0]   reg2_data_i,
  input  logic                ex_wreg_i,
  input  logic [RADDR_W-1:0]  ex_wd_i,
  input  logic [DATA_W-1:0]   ex_wdata_i,
  input  logic                ex_is_load_i,
  input  logic                mem_wreg_i,
  input  logic [RADDR_W-1:0]  mem_wd_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  input  logic                ex_ready_i,
  input  logic                flush_i,
  output logic                ex_valid_o,
  output logic [31:0]         ex_pc_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [ALUSEL_W-1:0] alusel_o,
  output logic [DATA_W-1:0]   reg1_o,
  output logic [DATA_W-1:0]   reg2_o,
  output logic [RADDR_W-1:0]  wd_o,
  output logic                wreg_o,
  output logic                is_load_o,
  output logic                inst_err_o,
  output logic [CNT_W-1:0]    stall_cnt_o
);

  localparam logic [ALUOP_W-1:0]  EXE_NOP_OP  = ALUOP_W'(8'b0000_0000);
  localparam logic [ALUOP_W-1:0]  EXE_AND_OP  = ALUOP_W'(8'b0010_0100);
  localparam logic [ALUOP_W-1:0]  EXE_OR_OP   = ALUOP_W'(8'b0010_0101);
  localparam logic [ALUOP_W-1:0]  EXE_XOR_OP  = ALUOP_W'(8'b0010_0110);
  localparam logic [ALUOP_W-1:0]  EXE_NOR_OP  = ALUOP_W'(8'b0010_0111);
  localparam logic [ALUOP_W-1:0]  EXE_SLL_OP  = ALUOP_W'(8'b0111_1100);
  localparam logic [ALUOP_W-1:0]  EXE_SRL_OP  = ALUOP_W'(8'b0000_0010);
  localparam logic [ALUOP_W-1:0]  EXE_SRA_OP  = ALUOP_W'(8'b0000_0011);
  localparam logic [ALUOP_W-1:0]  EXE_LW_OP   = ALUOP_W'(8'b1110_0011);
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP        = ALUSEL_W'(3'b000);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC      = ALUSEL_W'(3'b001);
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT      = ALUSEL_W'(3'b010);
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOAD_STORE = ALUSEL_W'(3'b111);

  logic [5:0]          op, funct;
  logic [RADDR_W-1:0]  rs, rt, rd;
  logic                d_r1_read, d_r2_read, d_wreg, d_load, d_err;
  logic [ALUOP_W-1:0]  d_aluop;
  logic [ALUSEL_W-1:0] d_alusel;
  logic [RADDR_W-1:0]  d_wd;
  logic [DATA_W-1:0]   d_imm, d_reg1, d_reg2;
  logic                r1_hit_ex, r2_hit_ex, r1_hit_mem, r2_hit_mem;
  logic                load_use, hazard;

  assign op    = inst_i[31:26];
  assign funct = inst_i[5:0];
  assign rs    = RADDR_W'(inst_i[25:21]);
  assign rt    = RADDR_W'(inst_i[20:16]);
  assign rd    = RADDR_W'(inst_i[15:11]);

  always_comb begin
    d_aluop   = EXE_NOP_OP;
    d_alusel  = EXE_RES_NOP;
    d_r1_read = 1'b0;
    d_r2_read = 1'b0;
    d_wd      = '0;
    d_wreg    = 1'b0;
    d_load    = 1'b0;
    d_err     = 1'b0;
    d_imm     = '0;
    case (op)
      6'h0c, 6'h0d, 6'h0e: begin
        d_aluop   = (op == 6'h0c) ? EXE_AND_OP : (op == 6'h0d) ? EXE_OR_OP : EXE_XOR_OP;
        d_alusel  = EXE_RES_LOGIC;
        d_r1_read = 1'b1;
        d_imm     = DATA_W'(inst_i[15:0]);
        d_wd      = rt;
        d_wreg    = 1'b1;
      end
      6'h0f: begin
        // Both ports carry the shifted immediate, so OR yields it unchanged.
        d_aluop  = EXE_OR_OP;
        d_alusel = EXE_RES_LOGIC;
        d_imm    = DATA_W'({inst_i[15:0], 16'h0000});
        d_wd     = rt;
        d_wreg   = 1'b1;
      end
      6'h23: begin
        d_aluop   = EXE_LW_OP;
        d_alusel  = EXE_RES_LOAD_STORE;
        d_r1_read = 1'b1;
        d_imm     = DATA_W'($signed(inst_i[15:0]));
        d_wd      = rt;
        d_wreg    = 1'b1;
        d_load    = 1'b1;
      end
      6'h00: begin
        if (inst_i != 32'h0) begin
          case (funct)
            6'h24, 6'h25, 6'h26, 6'h27: begin
              d_aluop   = (funct == 6'h24) ? EXE_AND_OP : (funct == 6'h25) ? EXE_OR_OP :
                          (funct == 6'h26) ? EXE_XOR_OP : EXE_NOR_OP;
              d_alusel  = EXE_RES_LOGIC;
              d_r1_read = 1'b1;
              d_r2_read = 1'b1;
              d_wd      = rd;
              d_wreg    = 1'b1;
            end
            6'h00, 6'h02, 6'h03: begin
              // Shift amount travels as reg1 through the disabled-read immediate path.
              d_aluop   = (funct == 6'h00) ? EXE_SLL_OP : (funct == 6'h02) ? EXE_SRL_OP : EXE_SRA_OP;
              d_alusel  = EXE_RES_SHIFT;
              d_r2_read = 1'b1;
              d_imm     = DATA_W'(inst_i[10:6]);
              d_wd      = rd;
              d_wreg    = 1'b1;
            end
            default: d_err = 1'b1;
          endcase
        end
      end
      default: d_err = 1'b1;
    endcase
  end

  function automatic logic [DATA_W-1:0] pick_operand(
    input logic               rd_en,
    input logic [RADDR_W-1:0] addr,
    input logic [DATA_W-1:0]  imm,
    input logic [DATA_W-1:0]  rf_data,
    input logic               exw,
    input logic [RADDR_W-1:0] exd,
    input logic [DATA_W-1:0]  exdata,
    input logic               memw,
    input logic [RADDR_W-1:0] memd,
    input logic [DATA_W-1:0]  memdata
  );
    logic [DATA_W-1:0] val;
    val = rf_data;
    if (!rd_en)                       val = imm;
    else if (addr == '0)              val = '0;
    else if (exw && exd == addr)      val = exdata;
`ifdef ID_MEM_FWD_EN
    else if (memw && memd == addr)    val = memdata;
`endif
    return val;
  endfunction

`ifndef ID_MEM_FWD_EN
  logic unused_mem_data;
  assign unused_mem_data = ^mem_wdata_i;
`endif

  assign d_reg1 = pick_operand(d_r1_read, rs, d_imm, reg1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i);
  assign d_reg2 = pick_operand(d_r2_read, rt, d_imm, reg2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                               mem_wreg_i, mem_wd_i, mem_wdata_i);

  assign r1_hit_ex  = d_r1_read && (rs != '0) && (rs == ex_wd_i);
  assign r2_hit_ex  = d_r2_read && (rt != '0) && (rt == ex_wd_i);
  assign r1_hit_mem = d_r1_read && (rs != '0) && (rs == mem_wd_i);
  assign r2_hit_mem = d_r2_read && (rt != '0) && (rt == mem_wd_i);
  assign load_use   = inst_valid_i && ex_is_load_i && ex_wreg_i && (r1_hit_ex || r2_hit_ex);

`ifdef ID_MEM_FWD_EN
  assign hazard = load_use;
`else
  assign hazard = load_use || (inst_valid_i && mem_wreg_i && (r1_hit_mem || r2_hit_mem));
`endif

  // Handshake: ID advances when id_ready_o is high; flush always frees ID.
  assign id_ready_o  = rst && (flush_i || (ex_ready_i && !hazard));
  assign reg1_read_o = rst && d_r1_read;
  assign reg2_read_o = rst && d_r2_read;
  assign reg1_addr_o = rst ? rs : '0;
  assign reg2_addr_o = rst ? rt : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid_o <= 1'b0;
      ex_pc_o    <= '0;
      aluop_o    <= EXE_NOP_OP;
      alusel_o   <= EXE_RES_NOP;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      is_load_o  <= 1'b0;
      inst_err_o <= 1'b0;
    end else if (flush_i || (ex_ready_i && (hazard || !inst_valid_i))) begin
      ex_valid_o <= 1'b0;
      ex_pc_o    <= '0;
      aluop_o    <= EXE_NOP_OP;
      alusel_o   <= EXE_RES_NOP;
      reg1_o     <= '0;
      reg2_o     <= '0;
      wd_o       <= '0;
      wreg_o     <= 1'b0;
      is_load_o  <= 1'b0;
      inst_err_o <= 1'b0;
    end else if (ex_ready_i) begin
      ex_valid_o <= 1'b1;
      ex_pc_o    <= pc_i;
      aluop_o    <= d_aluop;
      alusel_o   <= d_alusel;
      reg1_o     <= d_reg1;
      reg2_o     <= d_reg2;
      wd_o       <= d_wd;
      wreg_o     <= d_wreg;
      is_load_o  <= d_load;
      inst_err_o <= d_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_o <= '0;
    end else if (hazard && ex_ready_i && !flush_i && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_pipe.sv
// Scoreboard bench for id_pipe: expected ID/EX entries queued at drive time, popped after the edge.
module tb_id_pipe;

  localparam logic [7:0] OP_NOP = 8'h00, OP_AND = 8'h24, OP_OR = 8'h25, OP_XOR = 8'h26;
  localparam logic [7:0] OP_SLL = 8'h7C, OP_LW = 8'hE3;
  localparam logic [2:0] RES_NOP = 3'd0, RES_LOGIC = 3'd1, RES_SHIFT = 3'd2, RES_LS = 3'd7;

  logic        clk, rst;
  logic [31:0] pc_i, inst_i;
  logic        inst_valid_i, id_ready_o;
  logic        reg1_read_o, reg2_read_o;
  logic [4:0]  reg1_addr_o, reg2_addr_o;
  logic [31:0] reg1_data_i, reg2_data_i;
  logic        ex_wreg_i, ex_is_load_i, mem_wreg_i;
  logic [4:0]  ex_wd_i, mem_wd_i;
  logic [31:0] ex_wdata_i, mem_wdata_i;
  logic        ex_ready_i, flush_i;
  logic        ex_valid_o, wreg_o, is_load_o, inst_err_o;
  logic [31:0] ex_pc_o, reg1_o, reg2_o;
  logic [7:0]  aluop_o;
  logic [2:0]  alusel_o;
  logic [4:0]  wd_o;
  logic [3:0]  stall_cnt_o;

  logic [127:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_stall = 0;

  id_pipe #(.DATA_W(32), .RADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
    .id_ready_o(id_ready_o), .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .ex_ready_i(ex_ready_i), .flush_i(flush_i), .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o),
    .aluop_o(aluop_o), .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .is_load_o(is_load_o), .inst_err_o(inst_err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Regfile model: register n reads as F00D_00nn.
  assign reg1_data_i = {16'hF00D, 11'h0, reg1_addr_o};
  assign reg2_data_i = {16'hF00D, 11'h0, reg2_addr_o};

  function automatic logic [31:0] rf(input logic [4:0] a);
    return {16'hF00D, 11'h0, a};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, rt,
                                         input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_type(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [127:0] ent(input logic v, input logic [7:0] op, input logic [2:0] sel,
                                       input logic [31:0] r1, r2, input logic [4:0] wd,
                                       input logic wr, ld, er, input logic [31:0] pc);
    return {12'h0, v, op, sel, r1, r2, wd, wr, ld, er, pc};
  endfunction

  function automatic logic [127:0] dut_ent();
    return ent(ex_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, is_load_o,
               inst_err_o, ex_pc_o);
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input logic v);
    pc_i = pc;
    inst_i = inst;
    inst_valid_i = v;
    #1;
  endtask

  task automatic clr_wb();
    ex_wreg_i = 0; ex_wd_i = 0; ex_wdata_i = 0; ex_is_load_i = 0;
    mem_wreg_i = 0; mem_wd_i = 0; mem_wdata_i = 0;
  endtask

  // Scoreboard cycle: check id_ready, queue the entry expected after the edge, pop and compare.
  task automatic cycle_check(input string tag, input logic [127:0] e, input logic exp_rdy);
    logic [127:0] want;
    check({tag, "_rdy"}, {127'h0, id_ready_o}, {127'h0, exp_rdy});
    exp_q.push_back(e);
    step();
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 128'd0, 128'd1);
    end else begin
      want = exp_q.pop_front();
      check(tag, dut_ent(), want);
    end
    check({tag, "_cnt"}, {124'h0, stall_cnt_o}, 128'(exp_stall));
  endtask

  task automatic bump_stall();
    if (exp_stall < 15) exp_stall++;
  endtask

  initial begin
    logic [4:0]  rs, rt, exd;
    logic [15:0] imm;
    logic [31:0] exv, r1exp;
    logic        exw;

    rst = 0; flush_i = 0; ex_ready_i = 1;
    clr_wb();
    drive(32'h0, i_type(6'h0d, 5'd0, 5'd1, 16'h1100), 1'b1);
    #2;
    check("rst_entry", dut_ent(), 128'h0);
    check("rst_ready", {127'h0, id_ready_o}, 128'h0);
    check("rst_rd1", {127'h0, reg1_read_o}, 128'h0);
    check("rst_cnt", {124'h0, stall_cnt_o}, 128'h0);
    step();
    rst = 1;
    step();

    // ORI $1,$0,0x1100
    drive(32'h100, i_type(6'h0d, 5'd0, 5'd1, 16'h1100), 1'b1);
    check("ori_rd1", {122'h0, reg1_read_o, reg1_addr_o}, {122'h0, 1'b1, 5'd0});
    cycle_check("ori", ent(1, OP_OR, RES_LOGIC, 32'h0, 32'h1100, 5'd1, 1, 0, 0, 32'h100), 1);

    // OR $3,$1,$2 with EX writing $1, MEM writing $2
    ex_wreg_i = 1; ex_wd_i = 1; ex_wdata_i = 32'hAAAA0000;
    mem_wreg_i = 1; mem_wd_i = 2; mem_wdata_i = 32'h0000BBBB;
    drive(32'h104, r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 1'b1);
`ifdef ID_MEM_FWD_EN
    cycle_check("fwd_exmem", ent(1, OP_OR, RES_LOGIC, 32'hAAAA0000, 32'h0000BBBB, 5'd3, 1, 0, 0,
                                 32'h104), 1);
`else
    bump_stall();
    cycle_check("mem_stall", 128'h0, 0);
    mem_wreg_i = 0; #1;
    cycle_check("fwd_ex", ent(1, OP_OR, RES_LOGIC, 32'hAAAA0000, rf(5'd2), 5'd3, 1, 0, 0,
                              32'h104), 1);
`endif

    // EX and MEM both target $1: EX wins
    mem_wreg_i = 1; mem_wd_i = 1; mem_wdata_i = 32'h12345678;
    drive(32'h108, r_type(5'd1, 5'd2, 5'd3, 5'd0, 6'h25), 1'b1);
`ifdef ID_MEM_FWD_EN
    cycle_check("fwd_prio", ent(1, OP_OR, RES_LOGIC, 32'hAAAA0000, rf(5'd2), 5'd3, 1, 0, 0,
                                32'h108), 1);
`else
    bump_stall();
    cycle_check("mem_stall2", 128'h0, 0);
    mem_wreg_i = 0; #1;
    cycle_check("fwd_prio", ent(1, OP_OR, RES_LOGIC, 32'hAAAA0000, rf(5'd2), 5'd3, 1, 0, 0,
                                32'h108), 1);
`endif

    // Load-use: LW $4 in EX, AND $5,$4,$6 in ID
    clr_wb();
    ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1; ex_wdata_i = 32'h0BAD0BAD;
    drive(32'h10c, r_type(5'd4, 5'd6, 5'd5, 5'd0, 6'h24), 1'b1);
    check("lu_cnt_before", {124'h0, stall_cnt_o}, 128'(exp_stall));
    bump_stall();
    cycle_check("lu_stall", 128'h0, 0);
    clr_wb();
    mem_wreg_i = 1; mem_wd_i = 4; mem_wdata_i = 32'hDEAD0004;
    #1;
`ifdef ID_MEM_FWD_EN
    cycle_check("lu_issue", ent(1, OP_AND, RES_LOGIC, 32'hDEAD0004, rf(5'd6), 5'd5, 1, 0, 0,
                                32'h10c), 1);
`else
    bump_stall();
    cycle_check("lu_memstall", 128'h0, 0);
    mem_wreg_i = 0; #1;
    cycle_check("lu_issue", ent(1, OP_AND, RES_LOGIC, rf(5'd4), rf(5'd6), 5'd5, 1, 0, 0,
                                32'h10c), 1);
`endif
    clr_wb();

    // LW $4,-4($9)
    drive(32'h110, i_type(6'h23, 5'd9, 5'd4, 16'hFFFC), 1'b1);
    cycle_check("lw", ent(1, OP_LW, RES_LS, rf(5'd9), 32'hFFFFFFFC, 5'd4, 1, 1, 0, 32'h110), 1);

    // SLL $7,$8,4
    drive(32'h114, r_type(5'd0, 5'd8, 5'd7, 5'd4, 6'h00), 1'b1);
    check("sll_rd", {120'h0, reg1_read_o, reg2_read_o, 1'b0, reg2_addr_o},
          {120'h0, 1'b0, 1'b1, 1'b0, 5'd8});
    cycle_check("sll", ent(1, OP_SLL, RES_SHIFT, 32'd4, rf(5'd8), 5'd7, 1, 0, 0, 32'h114), 1);

    // All-zero NOP and undecodable opcode 0x3F
    drive(32'h118, 32'h0, 1'b1);
    cycle_check("nop", ent(1, OP_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h118), 1);
    drive(32'h11c, i_type(6'h3f, 5'd0, 5'd0, 16'h0), 1'b1);
    cycle_check("err", ent(1, OP_NOP, RES_NOP, 32'h0, 32'h0, 5'd0, 0, 0, 1, 32'h11c), 1);

    // Invalid slot loads a bubble
    drive(32'h120, i_type(6'h0d, 5'd0, 5'd1, 16'h1234), 1'b0);
    cycle_check("invalid", 128'h0, 1);

    // Back-pressure for 3 cycles, flush on the 2nd
    drive(32'h124, i_type(6'h0d, 5'd0, 5'd1, 16'h1100), 1'b1);
    cycle_check("bp_load", ent(1, OP_OR, RES_LOGIC, 32'h0, 32'h1100, 5'd1, 1, 0, 0, 32'h124), 1);
    ex_ready_i = 0;
    drive(32'h128, i_type(6'h0d, 5'd0, 5'd2, 16'h2222), 1'b1);
    cycle_check("bp_hold", ent(1, OP_OR, RES_LOGIC, 32'h0, 32'h1100, 5'd1, 1, 0, 0, 32'h124), 0);
    flush_i = 1; #1;
    cycle_check("bp_flush", 128'h0, 1);
    flush_i = 0; #1;
    cycle_check("bp_hold2", 128'h0, 0);
    ex_ready_i = 1; #1;
    cycle_check("bp_resume", ent(1, OP_OR, RES_LOGIC, 32'h0, 32'h2222, 5'd2, 1, 0, 0, 32'h128), 1);

    // Random XORI with random EX forwarding
    for (int i = 0; i < 24; i++) begin
      rs  = 5'($urandom_range(1, 31));
      rt  = 5'($urandom_range(0, 31));
      imm = 16'($urandom_range(0, 65535));
      exw = 1'($urandom_range(0, 1));
      exd = ($urandom_range(0, 1) == 1) ? rs : 5'($urandom_range(1, 31));
      exv = $urandom;
      ex_wreg_i = exw; ex_wd_i = exd; ex_wdata_i = exv;
      r1exp = (exw && exd == rs) ? exv : rf(rs);
      drive(32'h200 + 32'(i * 4), i_type(6'h0e, rs, rt, imm), 1'b1);
      cycle_check("xori_rand", ent(1, OP_XOR, RES_LOGIC, r1exp, {16'h0, imm}, rt, 1, 0, 0,
                                   32'h200 + 32'(i * 4)), 1);
    end
    clr_wb();

    // Saturation: 17 load-use hazard cycles on a 4-bit counter
    ex_wreg_i = 1; ex_wd_i = 4; ex_is_load_i = 1;
    drive(32'h300, r_type(5'd4, 5'd6, 5'd5, 5'd0, 6'h24), 1'b1);
    for (int i = 0; i < 17; i++) begin
      bump_stall();
      cycle_check("sat", 128'h0, 0);
    end
    check("sat_final", {124'h0, stall_cnt_o}, 128'hF);

    // Asynchronous reset while stalling
    #2;
    rst = 0;
    #1;
    check("mid_rst_cnt", {124'h0, stall_cnt_o}, 128'h0);
    check("mid_rst_ready", {127'h0, id_ready_o}, 128'h0);
    check("mid_rst_entry", dut_ent(), 128'h0);
    exp_stall = 0;
    step();
    clr_wb();
    rst = 1;
    drive(32'h400, i_type(6'h0d, 5'd3, 5'd9, 16'h00F0), 1'b1);
    cycle_check("post_rst", ent(1, OP_OR, RES_LOGIC, rf(5'd3), 32'h00F0, 5'd9, 1, 0, 0, 32'h400), 1);

    if (exp_q.size() != 0) check("sb_leftover", 128'(exp_q.size()), 128'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
